// File: rtl/retire_controller.sv
// In-order retirement sequencer for the active-list head. Released old_prd values
// are queued in a small FIFO that drains into the free list's single return port.
module retire_controller #(
  parameter int unsigned AL_SIZE      = 32,
  parameter int unsigned RETIRE_WIDTH = 2,
  parameter int unsigned PREG_W       = 6,
  parameter int unsigned FQ_DEPTH     = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               retire_block,
  input  logic [$clog2(AL_SIZE):0]           al_count,
  input  logic [RETIRE_WIDTH-1:0]            head_done,
  input  logic [RETIRE_WIDTH-1:0]            head_uses_rd,
  input  logic [RETIRE_WIDTH*PREG_W-1:0]     head_old_prd,
  output logic [RETIRE_WIDTH-1:0]            retire_valid,
  output logic [$clog2(RETIRE_WIDTH+1)-1:0]  retire_count,
  output logic                               fl_free_valid,
  output logic [PREG_W-1:0]                  fl_free_reg,
  input  logic                               fl_free_ready,
  output logic [31:0]                        retired_total
);

  localparam int unsigned AL_IDX_W = $clog2(AL_SIZE);
  localparam int unsigned PTR_W    = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W    = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned RC_W     = $clog2(RETIRE_WIDTH + 1);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t              state;
  logic [PREG_W-1:0]   fifo_mem [FQ_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    fifo_space;
  logic [RC_W-1:0]     push_cnt;
  logic [PREG_W-1:0]   push_data [RETIRE_WIDTH];
  logic                pop;

  // Retire mask: stop at the first entry that is not done, beyond al_count,
  // or whose cumulative frees would overflow the space left in the FIFO.
  always_comb begin
    logic             ok;
    logic [CNT_W-1:0] frees;
    retire_valid = '0;
    retire_count = '0;
    frees        = '0;
    fifo_space   = CNT_W'(FQ_DEPTH) - fifo_count;
    ok           = (state == RUN) && !flush && !retire_block && !reset;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      frees = frees + CNT_W'(head_uses_rd[k]);
      ok = ok && head_done[k] && ((AL_IDX_W+1)'(k) < al_count) && (frees <= fifo_space);
      retire_valid[k] = ok;
      retire_count    = retire_count + RC_W'(ok);
    end
  end

  // Compact the released registers of retiring entries into ascending push slots.
  always_comb begin
    push_cnt = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      push_data[j] = '0;
    end
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (retire_valid[k] && head_uses_rd[k]) begin
        push_data[push_cnt] = head_old_prd[k*PREG_W +: PREG_W];
        push_cnt = push_cnt + RC_W'(1);
      end
    end
  end

  assign fl_free_valid = (fifo_count != '0);
  assign fl_free_reg   = fl_free_valid ? fifo_mem[rd_ptr] : '0;
  assign pop           = fl_free_valid && fl_free_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      retired_total <= '0;
    end else begin
      state         <= flush ? HOLD : RUN;
      rd_ptr        <= rd_ptr + PTR_W'(pop);
      wr_ptr        <= wr_ptr + PTR_W'(push_cnt);
      fifo_count    <= fifo_count + CNT_W'(push_cnt) - CNT_W'(pop);
      retired_total <= retired_total + 32'(retire_count);
    end
  end

  // FIFO storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (RC_W'(k) < push_cnt) begin
        fifo_mem[wr_ptr + PTR_W'(k)] <= push_data[k];
      end
    end
  end

  a_thermometer: assert property (@(posedge clk) disable iff (reset)
    (retire_valid & RETIRE_WIDTH'(retire_valid + RETIRE_WIDTH'(1))) == '0);
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CNT_W'(FQ_DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push_cnt == '0) || (CNT_W'(push_cnt) <= fifo_space));

endmodule

// File: tb/tb_retire_controller.sv
// Self-checking bench for retire_controller: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_retire_controller;

  logic        clk = 1'b0;
  logic        reset, flush, retire_block, fl_free_ready;
  logic [5:0]  al_count;
  logic [1:0]  head_done, head_uses_rd;
  logic [11:0] head_old_prd;
  logic [1:0]  retire_valid, retire_count;
  logic        fl_free_valid;
  logic [5:0]  fl_free_reg;
  logic [31:0] retired_total;

  always #5 clk = ~clk;

  retire_controller dut (
    .clk(clk), .reset(reset), .flush(flush), .retire_block(retire_block),
    .al_count(al_count), .head_done(head_done), .head_uses_rd(head_uses_rd),
    .head_old_prd(head_old_prd), .retire_valid(retire_valid),
    .retire_count(retire_count), .fl_free_valid(fl_free_valid),
    .fl_free_reg(fl_free_reg), .fl_free_ready(fl_free_ready),
    .retired_total(retired_total)
  );

  // Reference model state
  logic [5:0]  mq[$];
  int unsigned m_total;
  bit          m_hold;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [5:0] al; logic [1:0] done; logic [1:0] uses;
    logic [5:0] p0; logic [5:0] p1; logic blk;
    logic [1:0] e_rv; logic e_fv; logic [5:0] e_reg; logic [31:0] e_total;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Number of entries the retire rules allow this cycle.
  function automatic int model_n();
    int f, n;
    if (reset || m_hold || flush || retire_block) return 0;
    f = 0; n = 0;
    for (int k = 0; k < 2; k++) begin
      if (k >= int'(al_count) || !head_done[k]) break;
      f += int'(head_uses_rd[k]);
      if (f > 4 - mq.size()) break;
      n++;
    end
    return n;
  endfunction

  task automatic step(input bit chk_regs);
    int n;
    #1;
    n = model_n();
    chk("retire_valid", 32'(retire_valid), 32'((1 << n) - 1));
    chk("retire_count", 32'(retire_count), 32'(n));
    if (chk_regs && !reset) begin
      chk("fl_free_valid", 32'(fl_free_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("fl_free_reg", 32'(fl_free_reg), 32'(mq[0]));
      chk("retired_total", retired_total, m_total);
    end
    @(posedge clk);
    if (reset) begin
      mq.delete(); m_total = 0; m_hold = 0;
    end else begin
      if (mq.size() != 0 && fl_free_ready) void'(mq.pop_front());
      for (int k = 0; k < n; k++)
        if (head_uses_rd[k]) mq.push_back(head_old_prd[k*6 +: 6]);
      m_total += 32'(n);
      m_hold = flush;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; retire_block = 0; al_count = 0; head_done = 0;
    head_uses_rd = 0; head_old_prd = 0; fl_free_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step(1);
    reset = 0;
  endtask

  initial begin
    mq.delete(); m_total = 0; m_hold = 0;
    idle_inputs();
    reset = 1;
    step(0);
    step(1);
    reset = 0;

    // al, done, uses, p0, p1, blk | rv, fv, reg, total
    vecs[0] = '{6'd2, 2'b11, 2'b11, 6'd5, 6'd9, 1'b0, 2'b11, 1'b0, 6'd0, 32'd0};
    vecs[1] = '{6'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 2'b00, 1'b1, 6'd5, 32'd2};
    vecs[2] = '{6'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 2'b00, 1'b1, 6'd9, 32'd2};
    vecs[3] = '{6'd2, 2'b10, 2'b00, 6'd0, 6'd0, 1'b0, 2'b00, 1'b0, 6'd0, 32'd2};
    vecs[4] = '{6'd2, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0, 2'b01, 1'b0, 6'd0, 32'd2};
    vecs[5] = '{6'd1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0, 2'b01, 1'b0, 6'd0, 32'd3};
    vecs[6] = '{6'd1, 2'b11, 2'b00, 6'd0, 6'd0, 1'b1, 2'b00, 1'b0, 6'd0, 32'd4};
    vecs[7] = '{6'd0, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 2'b00, 1'b0, 6'd0, 32'd4};
    for (int i = 0; i < 8; i++) begin
      al_count = vecs[i].al; head_done = vecs[i].done; head_uses_rd = vecs[i].uses;
      head_old_prd = {vecs[i].p1, vecs[i].p0}; retire_block = vecs[i].blk;
      #1;
      chk($sformatf("vec%0d_rv", i), 32'(retire_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_fv", i), 32'(fl_free_valid), 32'(vecs[i].e_fv));
      if (vecs[i].e_fv) chk($sformatf("vec%0d_reg", i), 32'(fl_free_reg), 32'(vecs[i].e_reg));
      chk($sformatf("vec%0d_total", i), retired_total, vecs[i].e_total);
      step(1);
    end

    // FIFO fills with the return port stalled; no credit for a same-cycle pop
    do_reset();
    fl_free_ready = 0; al_count = 2; head_done = 2'b11; head_uses_rd = 2'b11;
    head_old_prd = {6'd31, 6'd30};
    step(1);
    step(1);
    #1;
    chk("full_rv", 32'(retire_valid), 32'd0);
    chk("full_fv", 32'(fl_free_valid), 32'd1);
    step(1);
    fl_free_ready = 1;
    #1;
    chk("full_pop_no_credit_rv", 32'(retire_valid), 32'd0);
    step(1);
    fl_free_ready = 0;
    #1;
    chk("three_queued_rv", 32'(retire_valid), 32'b01);
    step(1);

    // Flush with two queued entries: two-cycle bubble, FIFO keeps draining
    do_reset();
    fl_free_ready = 0; al_count = 2; head_done = 2'b11; head_uses_rd = 2'b11;
    head_old_prd = {6'd21, 6'd20};
    step(1);
    flush = 1; fl_free_ready = 1; head_uses_rd = 2'b00;
    #1;
    chk("flush_rv", 32'(retire_valid), 32'd0);
    chk("flush_reg0", 32'(fl_free_reg), 32'd20);
    step(1);
    flush = 0;
    #1;
    chk("hold_rv", 32'(retire_valid), 32'd0);
    chk("hold_reg1", 32'(fl_free_reg), 32'd21);
    step(1);
    #1;
    chk("run_rv", 32'(retire_valid), 32'b11);
    chk("run_fv", 32'(fl_free_valid), 32'd0);
    step(1);

    // Pointer wrap with in-order draining, then reset mid-stream
    do_reset();
    al_count = 2; head_done = 2'b11; head_uses_rd = 2'b11; fl_free_ready = 1;
    for (int i = 0; i < 6; i++) begin
      head_old_prd = {6'(2*i + 41), 6'(2*i + 40)};
      step(1);
    end
    #1;
    chk("pre_reset_fv", 32'(fl_free_valid), 32'd1);
    reset = 1;
    step(1);
    reset = 0; idle_inputs();
    #1;
    chk("post_reset_fv", 32'(fl_free_valid), 32'd0);
    chk("post_reset_total", retired_total, 32'd0);
    step(1);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset         = ($urandom_range(63) == 0);
      flush         = ($urandom_range(7) == 0);
      retire_block  = ($urandom_range(7) == 0);
      fl_free_ready = 1'($urandom_range(1));
      al_count      = ($urandom_range(3) == 0) ? 6'($urandom_range(32)) : 6'($urandom_range(2));
      head_done     = 2'($urandom_range(3));
      head_uses_rd  = 2'($urandom_range(3));
      head_old_prd  = 12'($urandom);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
